// File: rtl/link_fault_injector.sv
// Inline fault injector for one credit-based NoC link: filters data packets on task IDs and injects a HANG stall or a CORRUPT flit.
// Optional fault log ports are enabled by defining FAULT_INJ_LOG_EN.
module link_fault_injector #(
   parameter int          FLIT_WIDTH = 32,
   parameter int          CNT_WIDTH  = 16,
   parameter logic [31:0] SERVICE_ID = 32'h1,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  cfg_en_i,
   input  logic [1:0]            cfg_mode_i,
   input  logic [31:0]           cfg_tick_begin_i,
   input  logic [CNT_WIDTH-1:0]  cfg_cycles_min_i,
   input  logic [CNT_WIDTH-1:0]  cfg_cycles_max_i,
   input  logic [7:0]            cfg_chance_i,
   input  logic [FLIT_WIDTH-1:0] cfg_corrupt_mask_i,
   input  logic [2:0]            cfg_filt_en_i,
   input  logic [7:0]            cfg_filt_app_i,
   input  logic [7:0]            cfg_filt_prod_i,
   input  logic [7:0]            cfg_filt_cons_i,
   input  logic                  tx_i,
   output logic                  cr_tx_o,
   input  logic                  eop_tx_i,
   input  logic [FLIT_WIDTH-1:0] data_tx_i,
   output logic                  rx_o,
   input  logic                  cr_rx_i,
   output logic                  eop_rx_o,
   output logic [FLIT_WIDTH-1:0] data_rx_o,
   output logic                  hang_o,
   output logic [15:0]           fault_cnt_o
`ifdef FAULT_INJ_LOG_EN
   ,
   output logic                  log_valid_o,
   output logic [31:0]           log_prod_o,
   output logic [31:0]           log_cons_o,
   output logic [31:0]           log_tick_o,
   output logic [CNT_WIDTH-1:0]  log_cycles_o
`endif
);

`ifdef FAULT_INJ_LOG_EN
   localparam int CAP_W = (FLIT_WIDTH < 32) ? FLIT_WIDTH : 32;
`else
   localparam int CAP_W = 16;
`endif

   typedef enum logic [3:0] {
      ST_HEADER, ST_SIZE, ST_SERVICE, ST_PROD, ST_CONS,
      ST_TIMESTAMP, ST_HANG, ST_CORRUPT, ST_EOP
   } state_t;

   state_t               state_reg, state_next;
   logic                 received;
   logic [31:0]          tick_reg;
   logic [15:0]          lfsr_reg;
   logic                 lfsr_fb;
   logic [CNT_WIDTH-1:0] hang_cnt_reg;
   logic [15:0]          fault_cnt_reg;
   logic [1:0]           mode_reg;
   logic [7:0]           chance_reg;
   logic [2:0]           filt_en_reg;
   logic [7:0]           filt_app_reg, filt_prod_reg, filt_cons_reg;
   logic [CAP_W-1:0]     prod_reg;
   logic [CNT_WIDTH-1:0] span, span_mask, lfsr_off, off_adj, hang_len;
   logic                 filt_ok, hit, hang_start, corrupt_done, fault_event;

   assign received = tx_i & cr_rx_i;
   assign lfsr_fb  = lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[3] ^ lfsr_reg[5];
   assign hit      = lfsr_reg[7:0] < chance_reg;

   // Offset mask: every bit at or below the MSB of span, i.e. smallest 2^k-1 >= span.
   assign span = cfg_cycles_max_i - cfg_cycles_min_i;
   generate
      for (genvar gi = 0; gi < CNT_WIDTH; gi++) begin : g_mask
         assign span_mask[gi] = |span[CNT_WIDTH-1:gi];
      end
   endgenerate
   assign lfsr_off = CNT_WIDTH'(lfsr_reg) & span_mask;
   assign off_adj  = (lfsr_off > span) ? (lfsr_off - span - 1'b1) : lfsr_off;
   assign hang_len = (cfg_cycles_max_i <= cfg_cycles_min_i) ? cfg_cycles_min_i
                                                            : cfg_cycles_min_i + off_adj;

   assign filt_ok = (!filt_en_reg[0] || (prod_reg[15:8] == filt_app_reg &&
                                         data_tx_i[15:8] == filt_app_reg)) &&
                    (!filt_en_reg[1] || prod_reg[7:0] == filt_prod_reg) &&
                    (!filt_en_reg[2] || data_tx_i[7:0] == filt_cons_reg);

   assign hang_start   = (state_reg == ST_TIMESTAMP) && (state_next == ST_HANG);
   assign corrupt_done = (state_reg == ST_CORRUPT) && received;
   assign fault_event  = hang_start | corrupt_done;
   assign fault_cnt_o  = fault_cnt_reg;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_reg <= ST_HEADER;
      else         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      if (state_reg == ST_HANG) begin
         if (hang_cnt_reg <= CNT_WIDTH'(1)) state_next = ST_EOP;
      end else if (received) begin
         if (eop_tx_i) begin
            state_next = ST_HEADER;
         end else begin
            case (state_reg)
               ST_HEADER:    state_next = (cfg_en_i && tick_reg >= cfg_tick_begin_i &&
                                           !cfg_mode_i[1]) ? ST_SIZE : ST_EOP;
               ST_SIZE:      state_next = ST_SERVICE;
               ST_SERVICE:   state_next = (data_tx_i == FLIT_WIDTH'(SERVICE_ID)) ? ST_PROD : ST_EOP;
               ST_PROD:      state_next = ST_CONS;
               ST_CONS:      state_next = filt_ok ? ST_TIMESTAMP : ST_EOP;
               ST_TIMESTAMP: begin
                  if (!hit)                             state_next = ST_EOP;
                  else if (mode_reg[0])                 state_next = ST_CORRUPT;
                  else if (hang_len != '0)              state_next = ST_HANG;
                  else                                  state_next = ST_EOP;
               end
               ST_CORRUPT:   state_next = ST_EOP;
               default:      state_next = ST_EOP;
            endcase
         end
      end
   end

   always_comb begin
      rx_o      = tx_i;
      cr_tx_o   = cr_rx_i;
      eop_rx_o  = eop_tx_i;
      data_rx_o = data_tx_i;
      hang_o    = 1'b0;
      case (state_reg)
         ST_HANG: begin
            rx_o     = 1'b0;
            cr_tx_o  = 1'b0;
            eop_rx_o = 1'b0;
            hang_o   = 1'b1;
         end
         ST_CORRUPT: data_rx_o = data_tx_i ^ cfg_corrupt_mask_i;
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tick_reg      <= '0;
         lfsr_reg      <= LFSR_SEED;
         hang_cnt_reg  <= '0;
         fault_cnt_reg <= '0;
         mode_reg      <= '0;
         chance_reg    <= '0;
         filt_en_reg   <= '0;
         filt_app_reg  <= '0;
         filt_prod_reg <= '0;
         filt_cons_reg <= '0;
         prod_reg      <= '0;
      end else begin
         tick_reg <= tick_reg + 32'd1;
         lfsr_reg <= {lfsr_fb, lfsr_reg[15:1]};
         if (hang_start)             hang_cnt_reg <= hang_len;
         else if (hang_cnt_reg != '0) hang_cnt_reg <= hang_cnt_reg - 1'b1;
         if (fault_event && fault_cnt_reg != 16'hFFFF) fault_cnt_reg <= fault_cnt_reg + 16'd1;
         // Packet-level config is frozen at the header so a packet is judged consistently.
         if (state_reg == ST_HEADER && received) begin
            mode_reg      <= cfg_mode_i;
            chance_reg    <= cfg_chance_i;
            filt_en_reg   <= cfg_filt_en_i;
            filt_app_reg  <= cfg_filt_app_i;
            filt_prod_reg <= cfg_filt_prod_i;
            filt_cons_reg <= cfg_filt_cons_i;
         end
         if (state_reg == ST_PROD && received) prod_reg <= data_tx_i[CAP_W-1:0];
      end
   end

`ifdef FAULT_INJ_LOG_EN
   logic [CAP_W-1:0] cons_reg;
   logic [31:0]      dec_tick_reg;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cons_reg     <= '0;
         dec_tick_reg <= '0;
         log_valid_o  <= 1'b0;
         log_prod_o   <= '0;
         log_cons_o   <= '0;
         log_tick_o   <= '0;
         log_cycles_o <= '0;
      end else begin
         log_valid_o <= fault_event;
         if (state_reg == ST_CONS && received)      cons_reg     <= data_tx_i[CAP_W-1:0];
         if (state_reg == ST_TIMESTAMP && received) dec_tick_reg <= tick_reg;
         if (fault_event) begin
            log_prod_o   <= 32'(prod_reg);
            log_cons_o   <= 32'(cons_reg);
            log_tick_o   <= hang_start ? tick_reg : dec_tick_reg;
            log_cycles_o <= hang_start ? hang_len : '0;
         end
      end
   end
`endif

endmodule

// File: tb/tb_link_fault_injector.sv
// Directed self-checking bench for link_fault_injector: pass-through, HANG, CORRUPT, filters and async reset.
module tb_link_fault_injector;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        cfg_en;
   logic [1:0]  cfg_mode;
   logic [31:0] cfg_tick_begin;
   logic [15:0] cfg_min, cfg_max;
   logic [7:0]  cfg_chance;
   logic [31:0] cfg_mask;
   logic [2:0]  cfg_filt_en;
   logic [7:0]  cfg_filt_app, cfg_filt_prod, cfg_filt_cons;
   logic        tx, eop_tx, cr_rx;
   logic [31:0] data_tx;
   logic        cr_tx_o, rx_o, eop_rx_o, hang_o;
   logic [31:0] data_rx_o;
   logic [15:0] fault_cnt_o;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_fault = 0;
   logic [15:0] lfsr_m;

   always #5 clk = ~clk;

   link_fault_injector dut (
      .clk_i(clk), .rst_ni(rst_ni), .cfg_en_i(cfg_en), .cfg_mode_i(cfg_mode),
      .cfg_tick_begin_i(cfg_tick_begin), .cfg_cycles_min_i(cfg_min), .cfg_cycles_max_i(cfg_max),
      .cfg_chance_i(cfg_chance), .cfg_corrupt_mask_i(cfg_mask), .cfg_filt_en_i(cfg_filt_en),
      .cfg_filt_app_i(cfg_filt_app), .cfg_filt_prod_i(cfg_filt_prod), .cfg_filt_cons_i(cfg_filt_cons),
      .tx_i(tx), .cr_tx_o(cr_tx_o), .eop_tx_i(eop_tx), .data_tx_i(data_tx),
      .rx_o(rx_o), .cr_rx_i(cr_rx), .eop_rx_o(eop_rx_o), .data_rx_o(data_rx_o),
      .hang_o(hang_o), .fault_cnt_o(fault_cnt_o)
   );

   // Reference LFSR (Fibonacci, taps 16,14,13,11, right-shifting form).
   always @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) lfsr_m <= 16'hACE1;
      else         lfsr_m <= (lfsr_m >> 1) | (16'(((lfsr_m >> 0) ^ (lfsr_m >> 2) ^
                                                  (lfsr_m >> 3) ^ (lfsr_m >> 5)) & 16'd1) << 15);
   end

   function automatic int exp_len(input int mn, input int mx, input logic [15:0] lf);
      int span, m, off;
      if (mx <= mn) return mn;
      span = mx - mn;
      m = 0;
      while (m < span) m = m * 2 + 1;
      off = int'(lf) & m;
      if (off > span) off = off - span - 1;
      return mn + off;
   endfunction

   task automatic set_cfg(input logic [1:0] mode, input logic [7:0] chance,
                          input logic [15:0] mn, input logic [15:0] mx);
      cfg_mode = mode; cfg_chance = chance; cfg_min = mn; cfg_max = mx;
   endtask

   // Drives one flit and waits for the credit; reports what appeared downstream when it was taken.
   task automatic send_flit(input logic [31:0] d, input logic e, input bit skip_ff,
                            output int stall, output logic [31:0] od, output logic orx,
                            output logic oeop, output bit bad, output logic [15:0] lf);
      @(negedge clk);
      while (skip_ff && lfsr_m[7:0] == 8'hFF) @(negedge clk);
      tx = 1'b1; data_tx = d; eop_tx = e; stall = 0; bad = 1'b0;
      #1;
      while (cr_tx_o !== 1'b1 && stall < 2000) begin
         if (rx_o !== 1'b0 || hang_o !== 1'b1 || eop_rx_o !== 1'b0) bad = 1'b1;
         stall++;
         @(negedge clk); #1;
      end
      od = data_rx_o; orx = rx_o; oeop = eop_rx_o; lf = lfsr_m;
      @(posedge clk); #1;
      tx = 1'b0; eop_tx = 1'b0;
   endtask

   task automatic send_pkt(input logic [31:0] prod, input logic [31:0] cons, input logic [31:0] pay,
                           output int pay_stall, output logic [31:0] pay_data, output logic pay_eop,
                           output bit flits_ok, output logic [15:0] ts_lfsr, output bit bad);
      logic [31:0] f [6];
      int st; logic [31:0] od; logic orx, oeop; bit bs; logic [15:0] lf;
      f[0] = 32'hA5A5_0001; f[1] = 32'd5; f[2] = 32'd1; f[3] = prod; f[4] = cons; f[5] = 32'd100;
      flits_ok = 1'b1; ts_lfsr = '0;
      for (int i = 0; i < 6; i++) begin
         send_flit(f[i], 1'b0, i == 5, st, od, orx, oeop, bs, lf);
         if (st != 0 || od !== f[i] || orx !== 1'b1 || oeop !== 1'b0) flits_ok = 1'b0;
         if (i == 5) ts_lfsr = lf;
      end
      send_flit(pay, 1'b1, 1'b0, pay_stall, pay_data, orx, pay_eop, bad, lf);
      if (orx !== 1'b1) flits_ok = 1'b0;
   endtask

   task automatic test_reset;
      n_checks++; if (fault_cnt_o !== 16'd0) begin n_fail++; $display("FAIL reset_fault_cnt got=%0d want=0", fault_cnt_o); end
      n_checks++; if (hang_o !== 1'b0) begin n_fail++; $display("FAIL reset_hang got=%b want=0", hang_o); end
      @(negedge clk);
      tx = 1'b1; data_tx = 32'hCAFE_F00D; cr_rx = 1'b0; #1;
      n_checks++; if (rx_o !== 1'b1 || data_rx_o !== 32'hCAFE_F00D || cr_tx_o !== 1'b0)
         begin n_fail++; $display("FAIL reset_passthru_a got rx=%b cr=%b d=%h want rx=1 cr=0 d=cafef00d", rx_o, cr_tx_o, data_rx_o); end
      tx = 1'b0; cr_rx = 1'b1; #1;
      n_checks++; if (rx_o !== 1'b0 || cr_tx_o !== 1'b1)
         begin n_fail++; $display("FAIL reset_passthru_b got rx=%b cr=%b want rx=0 cr=1", rx_o, cr_tx_o); end
   endtask

   task automatic test_passthrough;
      logic [31:0] f [7];
      int st; logic [31:0] od; logic orx, oeop; bit bs; logic [15:0] lf;
      f[0] = 32'hA5A5_0001; f[1] = 32'd5; f[2] = 32'd1; f[3] = 32'h0102; f[4] = 32'h0103;
      f[5] = 32'd100; f[6] = 32'h5555_AAAA;
      set_cfg(2'b00, 8'd0, 16'd20, 16'd20);
      for (int i = 0; i < 7; i++) begin
         send_flit(f[i], i == 6, 1'b0, st, od, orx, oeop, bs, lf);
         n_checks++;
         if (st != 0 || od !== f[i] || orx !== 1'b1 || oeop !== (i == 6))
            begin n_fail++; $display("FAIL passthru_flit%0d got d=%h rx=%b eop=%b stall=%0d want d=%h rx=1 eop=%0d stall=0", i, od, orx, oeop, st, f[i], i == 6); end
      end
      n_checks++; if (fault_cnt_o !== 16'(exp_fault)) begin n_fail++; $display("FAIL passthru_cnt got=%0d want=%0d", fault_cnt_o, exp_fault); end
   endtask

   task automatic test_hang;
      int st; logic [31:0] pd; logic pe; bit ok, bad; logic [15:0] lf;
      set_cfg(2'b00, 8'd255, 16'd20, 16'd20);
      send_pkt(32'h0102, 32'h0103, 32'h1111_2222, st, pd, pe, ok, lf, bad);
      exp_fault++;
      n_checks++; if (st != 20) begin n_fail++; $display("FAIL hang20_len got=%0d want=20", st); end
      n_checks++; if (bad) begin n_fail++; $display("FAIL hang20_outputs got rx/eop high or hang low during stall want rx=0 hang=1"); end
      n_checks++; if (!ok || pd !== 32'h1111_2222 || pe !== 1'b1)
         begin n_fail++; $display("FAIL hang20_payload got d=%h eop=%b ok=%b want d=11112222 eop=1 ok=1", pd, pe, ok); end
      n_checks++; if (fault_cnt_o !== 16'(exp_fault)) begin n_fail++; $display("FAIL hang20_cnt got=%0d want=%0d", fault_cnt_o, exp_fault); end
      n_checks++; if (hang_o !== 1'b0) begin n_fail++; $display("FAIL hang20_release got hang=%b want=0", hang_o); end
   endtask

   task automatic test_hang_range;
      int st, want, lo, hi; logic [31:0] pd; logic pe; bit ok, bad; logic [15:0] lf;
      logic [31:0] seen;
      seen = '0; lo = 1000; hi = -1;
      set_cfg(2'b00, 8'd255, 16'd5, 16'd12);
      for (int k = 0; k < 200; k++) begin
         send_pkt(32'h0102, 32'h0103, 32'(k), st, pd, pe, ok, lf, bad);
         want = exp_len(5, 12, lf);
         exp_fault++;
         n_checks++;
         if (st != want || !ok || bad)
            begin n_fail++; $display("FAIL range_pkt%0d got stall=%0d ok=%b bad=%b want stall=%0d ok=1 bad=0", k, st, ok, bad, want); end
         if (st < 32) seen[st] = 1'b1;
         if (st < lo) lo = st;
         if (st > hi) hi = st;
      end
      n_checks++; if (lo < 5 || hi > 12) begin n_fail++; $display("FAIL range_bounds got lo=%0d hi=%0d want within 5..12", lo, hi); end
      n_checks++; if ($countones(seen) < 4) begin n_fail++; $display("FAIL range_distinct got=%0d want>=4", $countones(seen)); end
      n_checks++; if (fault_cnt_o !== 16'(exp_fault)) begin n_fail++; $display("FAIL range_cnt got=%0d want=%0d", fault_cnt_o, exp_fault); end
      set_cfg(2'b00, 8'd255, 16'd0, 16'd0);
      send_pkt(32'h0102, 32'h0103, 32'h0, st, pd, pe, ok, lf, bad);
      n_checks++; if (st != 0 || !ok) begin n_fail++; $display("FAIL zero_len got stall=%0d ok=%b want stall=0 ok=1", st, ok); end
      n_checks++; if (fault_cnt_o !== 16'(exp_fault)) begin n_fail++; $display("FAIL zero_len_cnt got=%0d want=%0d", fault_cnt_o, exp_fault); end
   endtask

   task automatic test_filter;
      int st; logic [31:0] pd; logic pe; bit ok, bad; logic [15:0] lf;
      set_cfg(2'b00, 8'd255, 16'd4, 16'd4);
      cfg_filt_en = 3'b010; cfg_filt_prod = 8'h03;
      send_pkt(32'h0102, 32'h0103, 32'hABCD, st, pd, pe, ok, lf, bad);
      n_checks++; if (st != 0 || fault_cnt_o !== 16'(exp_fault))
         begin n_fail++; $display("FAIL filt_block got stall=%0d cnt=%0d want stall=0 cnt=%0d", st, fault_cnt_o, exp_fault); end
      send_pkt(32'h0103, 32'h0103, 32'hABCD, st, pd, pe, ok, lf, bad);
      exp_fault++;
      n_checks++; if (st != 4 || fault_cnt_o !== 16'(exp_fault))
         begin n_fail++; $display("FAIL filt_pass got stall=%0d cnt=%0d want stall=4 cnt=%0d", st, fault_cnt_o, exp_fault); end
      cfg_filt_en = 3'b000;
   endtask

   task automatic test_tick_begin;
      int st; logic [31:0] pd; logic pe; bit ok, bad; logic [15:0] lf;
      set_cfg(2'b00, 8'd255, 16'd5, 16'd5);
      cfg_tick_begin = 32'hFFFF_FFFF;
      send_pkt(32'h0102, 32'h0103, 32'h77, st, pd, pe, ok, lf, bad);
      n_checks++; if (st != 0 || fault_cnt_o !== 16'(exp_fault))
         begin n_fail++; $display("FAIL tick_begin got stall=%0d cnt=%0d want stall=0 cnt=%0d", st, fault_cnt_o, exp_fault); end
      cfg_tick_begin = 32'd0;
   endtask

   task automatic test_corrupt;
      int st; logic [31:0] pd; logic pe; bit ok, bad; logic [15:0] lf;
      set_cfg(2'b01, 8'd255, 16'd5, 16'd5);
      cfg_mask = 32'hFFFF_0000;
      send_pkt(32'h0102, 32'h0103, 32'h1234_5678, st, pd, pe, ok, lf, bad);
      exp_fault++;
      n_checks++; if (pd !== 32'hEDCB_5678 || st != 0 || pe !== 1'b1)
         begin n_fail++; $display("FAIL corrupt_payload got d=%h stall=%0d eop=%b want d=edcb5678 stall=0 eop=1", pd, st, pe); end
      n_checks++; if (!ok) begin n_fail++; $display("FAIL corrupt_other_flits got changed want unchanged"); end
      n_checks++; if (fault_cnt_o !== 16'(exp_fault)) begin n_fail++; $display("FAIL corrupt_cnt got=%0d want=%0d", fault_cnt_o, exp_fault); end
      cfg_chance = 8'd0;
      send_pkt(32'h0102, 32'h0103, 32'h1234_5678, st, pd, pe, ok, lf, bad);
      n_checks++; if (pd !== 32'h1234_5678 || !ok || fault_cnt_o !== 16'(exp_fault))
         begin n_fail++; $display("FAIL corrupt_next_clean got d=%h ok=%b cnt=%0d want d=12345678 ok=1 cnt=%0d", pd, ok, fault_cnt_o, exp_fault); end
   endtask

   task automatic test_reset_mid_hang;
      int st; logic [31:0] od, pd; logic orx, oeop, pe; bit bs, ok, bad; logic [15:0] lf;
      logic [31:0] f [6];
      f[0] = 32'hA5A5_0001; f[1] = 32'd5; f[2] = 32'd1; f[3] = 32'h0102; f[4] = 32'h0103; f[5] = 32'd100;
      set_cfg(2'b00, 8'd255, 16'd50, 16'd50);
      for (int i = 0; i < 6; i++) send_flit(f[i], 1'b0, i == 5, st, od, orx, oeop, bs, lf);
      @(negedge clk);
      tx = 1'b1; data_tx = 32'h9999_0000; eop_tx = 1'b1;
      repeat (9) @(negedge clk);
      #1;
      n_checks++; if (hang_o !== 1'b1 || cr_tx_o !== 1'b0)
         begin n_fail++; $display("FAIL midhang_active got hang=%b cr=%b want hang=1 cr=0", hang_o, cr_tx_o); end
      rst_ni = 1'b0; #1;
      exp_fault = 0;
      n_checks++; if (hang_o !== 1'b0 || cr_tx_o !== 1'b1 || rx_o !== 1'b1 || eop_rx_o !== 1'b1 || data_rx_o !== 32'h9999_0000)
         begin n_fail++; $display("FAIL midhang_release got hang=%b cr=%b rx=%b eop=%b d=%h want 0 1 1 1 99990000", hang_o, cr_tx_o, rx_o, eop_rx_o, data_rx_o); end
      n_checks++; if (fault_cnt_o !== 16'd0) begin n_fail++; $display("FAIL midhang_cnt got=%0d want=0", fault_cnt_o); end
      tx = 1'b0; eop_tx = 1'b0;
      repeat (2) @(negedge clk);
      rst_ni = 1'b1;
      set_cfg(2'b00, 8'd255, 16'd3, 16'd3);
      send_flit(32'hA5A5_0002, 1'b0, 1'b0, st, od, orx, oeop, bs, lf);
      send_flit(32'd1, 1'b1, 1'b0, st, od, orx, oeop, bs, lf);
      n_checks++; if (st != 0 || od !== 32'd1 || oeop !== 1'b1)
         begin n_fail++; $display("FAIL short_pkt got stall=%0d d=%h eop=%b want 0 00000001 1", st, od, oeop); end
      send_pkt(32'h0102, 32'h0103, 32'h4242, st, pd, pe, ok, lf, bad);
      exp_fault++;
      n_checks++; if (st != 3 || !ok || bad || fault_cnt_o !== 16'(exp_fault))
         begin n_fail++; $display("FAIL after_short got stall=%0d ok=%b cnt=%0d want stall=3 ok=1 cnt=%0d", st, ok, fault_cnt_o, exp_fault); end
   endtask

   initial begin
      rst_ni = 1'b0; cfg_en = 1'b1; cfg_mode = 2'b00; cfg_tick_begin = 32'd0;
      cfg_min = 16'd0; cfg_max = 16'd0; cfg_chance = 8'd0; cfg_mask = 32'd0;
      cfg_filt_en = 3'b000; cfg_filt_app = 8'h01; cfg_filt_prod = 8'h00; cfg_filt_cons = 8'h00;
      tx = 1'b0; eop_tx = 1'b0; cr_rx = 1'b1; data_tx = 32'd0;
      repeat (3) @(negedge clk);
      rst_ni = 1'b1;
      test_reset;
      test_passthrough;
      test_hang;
      test_hang_range;
      test_filter;
      test_tick_begin;
      test_corrupt;
      test_reset_mid_hang;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/link_fault_injector.md
Name: link_fault_injector

Overview:
- Parametrised successor to the single-port link hang emulator: sits inline on one credit-based NoC link, between router output and neighbour input.
- Parses packet headers and filters on producer/consumer task IDs.
- On a random hit, injects one fault: a link stall (HANG) or payload corruption (CORRUPT).
- Fully synthesizable: run-time config ports replace file config, an LFSR replaces simulator random, an internal tick counter replaces simulation time.

Parameters:
- FLIT_WIDTH, 32, flit data width (>=16).
- CNT_WIDTH, 16, width of hang-cycle counter and cycle bounds.
- SERVICE_ID, 32'h1, service word that marks a filterable data packet.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- cfg_en_i  in  1  injector enable; sampled only in HEADER
- cfg_mode_i  in  2  00 HANG, 01 CORRUPT, 10/11 pass-through
- cfg_tick_begin_i  in  32  first tick at which injection is allowed
- cfg_cycles_min_i  in  CNT_WIDTH  minimum hang length
- cfg_cycles_max_i  in  CNT_WIDTH  maximum hang length
- cfg_chance_i  in  8  hit threshold; probability = chance/256
- cfg_corrupt_mask_i  in  FLIT_WIDTH  XOR mask applied in CORRUPT
- cfg_filt_en_i  in  3  enables for {cons, prod, app} filters
- cfg_filt_app_i / cfg_filt_prod_i / cfg_filt_cons_i  in  8 each  filter values
- tx_i  in  1  upstream valid
- cr_tx_o  out  1  credit to upstream
- eop_tx_i  in  1  upstream end-of-packet
- data_tx_i  in  FLIT_WIDTH  upstream flit
- rx_o  out  1  downstream valid
- cr_rx_i  in  1  downstream credit
- eop_rx_o  out  1  downstream end-of-packet
- data_rx_o  out  FLIT_WIDTH  downstream flit
- hang_o  out  1  high while in HANG
- fault_cnt_o  out  16  number of injected faults, saturating

Behaviour:
- Reset values:
  - state HEADER, tick 0, lfsr LFSR_SEED, fault_cnt_o 0, hang_o 0.
  - Pass-through outputs follow their inputs combinationally.
- Core signals:
  - received = tx_i & cr_rx_i.
  - tick: free-running 32-bit counter, wraps.
  - lfsr: 16-bit Fibonacci, taps 16,14,13,11, advances every clock.
- Outputs outside HANG/CORRUPT: pass-through, zero latency (rx_o=tx_i, cr_tx_o=cr_rx_i, eop_rx_o=eop_tx_i, data_rx_o=data_tx_i).
- HANG outputs: rx_o=0, cr_tx_o=0, eop_rx_o=0, data_rx_o passes through.
- FSM (advances only on received unless noted):
  - HEADER → SIZE if cfg_en_i, tick>=cfg_tick_begin_i and mode<2; otherwise → EOP.
  - SIZE → SERVICE.
  - SERVICE → PROD if data==SERVICE_ID; otherwise → EOP.
  - PROD: capture producer → CONS.
  - CONS: capture consumer. Evaluate filters on captured producer (app=producer[15:8], prod=producer[7:0]) and data_tx_i consumer (app=[15:8], cons=[7:0]). A disabled filter passes. Any mismatch → EOP; else → TIMESTAMP.
  - TIMESTAMP (on received): hit = lfsr[7:0] < cfg_chance_i.
    - No hit → EOP.
    - Hit with HANG mode and computed length > 0 → HANG; load counter, increment fault_cnt_o.
    - Hit with HANG mode and length 0 → EOP, no count.
    - Hit with CORRUPT mode → CORRUPT.
  - HANG: counter decrements every clock regardless of traffic; counter==1 → EOP; total stall = length cycles.
  - CORRUPT: on received, data_rx_o = data_tx_i ^ cfg_corrupt_mask_i for that one flit; increment fault_cnt_o; → HEADER if eop_tx_i else → EOP.
  - EOP: received & eop_tx_i → HEADER.
- Any state except HANG: received & eop_tx_i → HEADER. Short packets never desynchronise the FSM.
- Hang length:
  - span = max-min; if max<=min, length = min.
  - Otherwise off = lfsr[15:0] masked to the smallest power-of-two mask >= span.
  - If off>span, off = off-span-1.
  - length = min+off; always lies in [min,max].
- fault_cnt_o saturates at 16'hFFFF.
- Async reset mid-HANG releases the link immediately (pass-through).
- Config changes take effect at the next HEADER; only mask and counter limits are read live.

Optional Feature:
- Macro FAULT_INJ_LOG_EN.
- When defined: adds outputs log_valid_o (1-cycle pulse on each injected fault), log_prod_o[31:0], log_cons_o[31:0], log_tick_o[31:0] (tick at decision) and log_cycles_o[CNT_WIDTH-1:0] (0 for CORRUPT). Log registers reset to 0.
- When undefined: these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Reset, then send packet {hdr, size 5, service 1, prod 0x0102, cons 0x0103, ts 100, eop-payload} with chance=0 → all 7 flits pass unchanged, zero latency, fault_cnt_o=0.
- chance=255, HANG mode, min=max=20, filters off → after TIMESTAMP, rx_o/cr_tx_o low exactly 20 cycles and hang_o high, then payload delivered; fault_cnt_o=1.
- min=5, max=12 over 200 hits → every stall length within 5..12 and at least 4 distinct values; min=max=0 → no stall, no count.
- Prod filter enabled with value 0x03, packet prod 0x0102 → no fault; rewrite prod to 0x0103 → fault.
- CORRUPT mode, mask 0xFFFF0000, payload flit 0x12345678 → downstream receives 0xEDCB5678, only that flit changed; next packet starts clean from HEADER.
- Assert rst_ni low at cycle 10 of a 50-cycle hang → outputs pass through immediately; state HEADER, fault_cnt_o=0; a 2-flit packet with early eop returns to HEADER.
